poly_mult_host_if: RTL and testbench
====================================

POLY_MULT_HOST_IF -- requirements
Module: poly_mult_host_if

Interface
REQ-001 SHALL have parameter DATA_W, default 128: host command/response data width.
REQ-002 SHALL have parameter WORD_W, default 32: random-vector and result word width.
REQ-003 SHALL have parameter POS_W, default 16: shift-position entry width.
REQ-004 SHALL have parameter MAX_WEIGHT, default 75: position RAM depth and upper bound on runtime weight.
REQ-005 SHALL have parameter VEC_DEPTH, default 553: random-vector RAM depth in words.
REQ-006 SHALL have parameter RES_DEPTH, default 1106: result word count.
REQ-007 SHALL have port clk, input, 1: the single clock; the block has one clock.
REQ-008 SHALL have port rst, input, 1: reset is synchronous and active-low.
REQ-009 SHALL have port cmd_valid_i, input, 1: command offered.
REQ-010 SHALL have port cmd_ready_o, output, 1: command accepted when both it and cmd_valid_i are high.
REQ-011 SHALL have port cmd_op_i, input, 3: opcode. 0 WR_POS, 1 WR_VEC, 2 RD_POS, 3 RD_VEC, 4 SET_WEIGHT, 5 START, 6 RD_RES, 7 reserved.
REQ-012 SHALL have port cmd_addr_i, input, 11: entry index.
REQ-013 SHALL have port cmd_data_i, input, DATA_W: write data, LSB-aligned.
REQ-014 SHALL have port rsp_valid_o, output, 1: one-cycle response strobe.
REQ-015 SHALL have port rsp_data_o, output, DATA_W: read data, zero-extended; 0 for non-reads.
REQ-016 SHALL have port rsp_err_o, output, 1: error flag, valid with rsp_valid_o.
REQ-017 SHALL have port busy_o, output, 1: high while in any state other than IDLE.
REQ-018 SHALL have ports mem_we_o (1), mem_sel_o (1; 0 = position RAM, 1 = vector RAM), mem_addr_o (11) and mem_wdata_o (WORD_W), all outputs: shared memory write/read port.
REQ-019 SHALL have ports pos_rdata_i (input, POS_W) and vec_rdata_i (input, WORD_W): RAM read data with 1-cycle read latency.
REQ-020 SHALL have ports core_start_o (output, 1), core_weight_o (output, 11), core_valid_i (input, 1), core_raddr_o (output, 11) and core_dout_i (input, WORD_W): multiplier core control and result readout.

Function
REQ-021 SHALL implement FSM states IDLE, MEMRD, RUN, RESRD and RESP; cmd_ready_o is high only in IDLE.
REQ-022 WR_POS and WR_VEC SHALL behave as follows:
- On accept with an in-range address, assert mem_we_o for that cycle, with mem_wdata_o set to the low POS_W or WORD_W bits of cmd_data_i.
- Go to RESP.
- rsp_valid_o is asserted the cycle after accept.
REQ-023 RD_POS, RD_VEC and RD_RES SHALL behave as follows:
- On accept, drive the address.
- MEMRD or RESRD samples the read data next cycle.
- RESP strobes rsp_valid_o 2 cycles after accept.
REQ-024 Address ranges SHALL be: WR_POS/RD_POS need address < MAX_WEIGHT; WR_VEC/RD_VEC need address < VEC_DEPTH; RD_RES needs address < RES_DEPTH; otherwise no memory access, rsp_err_o=1, and the response comes 1 cycle after accept.
REQ-025 SET_WEIGHT SHALL latch cmd_data_i[10:0] into core_weight_o; a value of 0 or greater than MAX_WEIGHT SHALL keep the old value and set rsp_err_o=1.
REQ-026 START SHALL behave as follows:
- If weight is 0, respond with error.
- Otherwise pulse core_start_o for exactly 1 cycle, clear the done flag and enter RUN.
- In RUN, the first cycle with core_valid_i=1 sets the done flag and goes to RESP with rsp_err_o=0.
REQ-027 RD_RES issued while the done flag is clear SHALL respond with rsp_err_o=1.
REQ-028 Opcode 7 SHALL respond with rsp_err_o=1 one cycle after accept.
REQ-029 Any write command SHALL clear the done flag.
REQ-030 core_valid_i outside RUN SHALL be ignored.
REQ-031 RESP SHALL last exactly 1 cycle and then return to IDLE; back-to-back commands are accepted every 2 (write) or 3 (read) cycles.

Reset
REQ-032 While rst=0 at a clock edge, the block SHALL go to IDLE, and the following SHALL all be 0: cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o, core_start_o, core_raddr_o, core_weight_o and the done flag.
REQ-033 Reset asserted mid-RUN SHALL abandon the run with no response strobe; cmd_ready_o SHALL be 1 in the first cycle after rst returns high.

Configuration
REQ-034 Macro POLY_HOST_READBACK_EN SHALL control readback:
- When defined, RD_POS and RD_VEC operate per REQ-023.
- When undefined, they respond 1 cycle after accept with rsp_err_o=1 and rsp_data_o=0; pos_rdata_i and vec_rdata_i are unused.
- RD_RES is unaffected either way.

Verification
REQ-035 The bench SHALL check: WR_POS addr 3 data 0x1A2B, then RD_POS addr 3 -> rsp_data_o=0x1A2B, err 0, strobe 2 cycles after accept.
REQ-036 The bench SHALL check: WR_VEC addr 553 -> no mem_we_o, rsp_err_o=1; WR_VEC addr 552 data 0xDEADBEEF -> mem_we_o with sel=1, addr 552.
REQ-037 The bench SHALL check: SET_WEIGHT 66, START, core_valid_i at cycle 40 -> single core_start_o pulse; busy_o high for cycles 1-40; response err 0.
REQ-038 The bench SHALL check: RD_RES addr 0 before START -> err 1; after a completed run with core_dout_i=0x12345678 -> rsp_data_o=0x12345678.
REQ-039 The bench SHALL check: rst=0 during RUN -> all outputs 0; after release, RD_RES -> err 1 (done flag cleared).
REQ-040 The bench SHALL check, with POLY_HOST_READBACK_EN undefined: RD_POS addr 0 -> err 1 one cycle after accept, and no memory address change.

Source files
------------

// File: rtl/poly_mult_host_if.sv
// Host command front-end for the polynomial multiplier: RAM writes and reads, weight set-up, core start and result readout.
// Latency: writes, SET_WEIGHT, errors and START completion respond 1 cycle after the deciding cycle; reads respond 2 cycles after accept.
// Backpressure: one command in flight, so cmd_ready_o is high only in IDLE. RAM readback is built only when POLY_HOST_READBACK_EN is defined.
module poly_mult_host_if #(
    parameter int DATA_W     = 128,
    parameter int WORD_W     = 32,
    parameter int POS_W      = 16,
    parameter int MAX_WEIGHT = 75,
    parameter int VEC_DEPTH  = 553,
    parameter int RES_DEPTH  = 1106
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [10:0]       cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              mem_we_o,
    output logic              mem_sel_o,
    output logic [10:0]       mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [POS_W-1:0]  pos_rdata_i,
    input  logic [WORD_W-1:0] vec_rdata_i,
    output logic              core_start_o,
    output logic [10:0]       core_weight_o,
    input  logic              core_valid_i,
    output logic [10:0]       core_raddr_o,
    input  logic [WORD_W-1:0] core_dout_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MEMRD = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_RESRD = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [2:0] OP_WR_POS = 3'd0;
    localparam logic [2:0] OP_WR_VEC = 3'd1;
    localparam logic [2:0] OP_RD_POS = 3'd2;
    localparam logic [2:0] OP_RD_VEC = 3'd3;
    localparam logic [2:0] OP_SET_W  = 3'd4;
    localparam logic [2:0] OP_START  = 3'd5;
    localparam logic [2:0] OP_RD_RES = 3'd6;

    localparam logic [11:0] POS_LIM = 12'(MAX_WEIGHT);
    localparam logic [11:0] VEC_LIM = 12'(VEC_DEPTH);
    localparam logic [11:0] RES_LIM = 12'(RES_DEPTH);

    logic [2:0]        state_q, state_d;
    logic              done_q, done_d;
    logic [10:0]       weight_q, weight_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [10:0]       addr_q, addr_d;
    logic              sel_q, sel_d;
    logic [10:0]       raddr_q, raddr_d;
    logic              start_q, start_d;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;

    logic              accept;
    logic [11:0]       addr_x;
    logic [11:0]       wt_x;
    logic              pos_ok, vec_ok, res_ok, wt_ok;
    logic              unused_in;

    // Holding cmd_ready_o low while rst is low keeps the reset outputs at zero and lets it rise as soon as reset is released.
    assign cmd_ready_o = rst & (state_q == S_IDLE);
    assign accept      = cmd_valid_i & cmd_ready_o;

    assign addr_x = {1'b0, cmd_addr_i};
    assign wt_x   = {1'b0, cmd_data_i[10:0]};
    assign pos_ok = addr_x < POS_LIM;
    assign vec_ok = addr_x < VEC_LIM;
    assign res_ok = addr_x < RES_LIM;
    assign wt_ok  = (wt_x != 12'd0) && (wt_x <= POS_LIM);

    // Only the low data bits are consumed, and the RAM read data is not consumed at all when readback is compiled out.
    assign unused_in = ^{cmd_data_i, pos_rdata_i, vec_rdata_i};

    // Command decode and FSM next state. The RAM address and sel are driven combinationally in the accept cycle so the 1-cycle RAM data lands in MEMRD.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        weight_d  = weight_q;
        err_d     = err_q;
        data_d    = data_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        raddr_d   = raddr_q;
        start_d   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d   = 1'b0;
                    data_d  = '0;
                    state_d = S_RESP;
                    case (cmd_op_i)
                        OP_WR_POS: begin
                            done_d = 1'b0;
                            if (pos_ok) begin
                                mem_we    = 1'b1;
                                mem_wdata = WORD_W'(cmd_data_i[POS_W-1:0]);
                                addr_d    = cmd_addr_i;
                                sel_d     = 1'b0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_WR_VEC: begin
                            done_d = 1'b0;
                            if (vec_ok) begin
                                mem_we    = 1'b1;
                                mem_wdata = cmd_data_i[WORD_W-1:0];
                                addr_d    = cmd_addr_i;
                                sel_d     = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
`ifdef POLY_HOST_READBACK_EN
                        OP_RD_POS: begin
                            if (pos_ok) begin
                                addr_d  = cmd_addr_i;
                                sel_d   = 1'b0;
                                state_d = S_MEMRD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_RD_VEC: begin
                            if (vec_ok) begin
                                addr_d  = cmd_addr_i;
                                sel_d   = 1'b1;
                                state_d = S_MEMRD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
`else
                        OP_RD_POS: err_d = 1'b1;
                        OP_RD_VEC: err_d = 1'b1;
`endif
                        OP_SET_W: begin
                            if (wt_ok) begin
                                weight_d = cmd_data_i[10:0];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_START: begin
                            if (weight_q == 11'd0) begin
                                err_d = 1'b1;
                            end else begin
                                start_d = 1'b1;
                                done_d  = 1'b0;
                                state_d = S_RUN;
                            end
                        end
                        OP_RD_RES: begin
                            if (res_ok && done_q) begin
                                raddr_d = cmd_addr_i;
                                state_d = S_RESRD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_MEMRD: begin
`ifdef POLY_HOST_READBACK_EN
                data_d = sel_q ? DATA_W'(vec_rdata_i) : DATA_W'(pos_rdata_i);
`else
                data_d = '0;
`endif
                state_d = S_RESP;
            end
            S_RESRD: begin
                data_d  = DATA_W'(core_dout_i);
                state_d = S_RESP;
            end
            S_RUN: begin
                if (core_valid_i) begin
                    done_d  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and held values; reset abandons any run without a response and clears the done flag and weight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            weight_q <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            sel_q    <= 1'b0;
            raddr_q  <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            weight_q <= weight_d;
            err_q    <= err_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            raddr_q  <= raddr_d;
            start_q  <= start_d;
        end
    end

    assign busy_o        = state_q != S_IDLE;
    assign rsp_valid_o   = state_q == S_RESP;
    assign rsp_err_o     = rsp_valid_o & err_q;
    assign rsp_data_o    = rsp_valid_o ? data_q : '0;
    assign mem_we_o      = mem_we;
    assign mem_wdata_o   = mem_wdata;
    assign mem_addr_o    = addr_d;
    assign mem_sel_o     = sel_d;
    assign core_raddr_o  = raddr_d;
    assign core_start_o  = start_q;
    assign core_weight_o = weight_q;

endmodule

// File: tb/tb_poly_mult_host_if.sv
// Randomized self-checking bench for poly_mult_host_if with RAM and core models.
// Checks every response against a behavioural model of the command set.
// Directed cases cover reset, boundary addresses, a 40-cycle run and reset during a run.
module tb_poly_mult_host_if;
    localparam int MAXW = 75;
    localparam int VECD = 553;
    localparam int RESD = 1106;
`ifdef POLY_HOST_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [2:0]   cmd_op_i;
    logic [10:0]  cmd_addr_i;
    logic [127:0] cmd_data_i;
    logic         rsp_valid_o;
    logic [127:0] rsp_data_o;
    logic         rsp_err_o;
    logic         busy_o;
    logic         mem_we_o;
    logic         mem_sel_o;
    logic [10:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic [15:0]  pos_rdata_i;
    logic [31:0]  vec_rdata_i;
    logic         core_start_o;
    logic [10:0]  core_weight_o;
    logic         core_valid_i;
    logic [10:0]  core_raddr_o;
    logic [31:0]  core_dout_i;

    poly_mult_host_if dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .pos_rdata_i(pos_rdata_i), .vec_rdata_i(vec_rdata_i),
        .core_start_o(core_start_o), .core_weight_o(core_weight_o),
        .core_valid_i(core_valid_i), .core_raddr_o(core_raddr_o), .core_dout_i(core_dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAMs and core result buffer, all with 1-cycle read latency.
    logic [15:0] pos_ram [MAXW];
    logic [31:0] vec_ram [VECD];
    logic [31:0] res_ram [RESD];

    always @(posedge clk) begin
        if (mem_we_o && !mem_sel_o && mem_addr_o < MAXW) pos_ram[mem_addr_o] <= mem_wdata_o[15:0];
        if (mem_we_o && mem_sel_o && mem_addr_o < VECD) vec_ram[mem_addr_o] <= mem_wdata_o;
        pos_rdata_i <= (mem_addr_o < MAXW) ? pos_ram[mem_addr_o] : 16'd0;
        vec_rdata_i <= (mem_addr_o < VECD) ? vec_ram[mem_addr_o] : 32'd0;
        core_dout_i <= (core_raddr_o < RESD) ? res_ram[core_raddr_o] : 32'd0;
    end

    // Reference model state.
    logic [15:0] pos_m [MAXW];
    logic [31:0] vec_m [VECD];
    logic [10:0] m_w;
    bit          m_done;
    logic [10:0] m_addr;
    logic        m_sel;

    // Observations from the most recent command.
    int           o_lat, o_pulses, o_busy_lo;
    logic [127:0] o_rd;
    logic         o_err, o_we, o_sel;
    logic [10:0]  o_ma;
    logic [31:0]  o_wd;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string p);
        chk({p, ".cmd_ready_o"},   128'(cmd_ready_o),   128'd0);
        chk({p, ".rsp_valid_o"},   128'(rsp_valid_o),   128'd0);
        chk({p, ".rsp_data_o"},    rsp_data_o,          128'd0);
        chk({p, ".rsp_err_o"},     128'(rsp_err_o),     128'd0);
        chk({p, ".busy_o"},        128'(busy_o),        128'd0);
        chk({p, ".mem_we_o"},      128'(mem_we_o),      128'd0);
        chk({p, ".mem_sel_o"},     128'(mem_sel_o),     128'd0);
        chk({p, ".mem_addr_o"},    128'(mem_addr_o),    128'd0);
        chk({p, ".mem_wdata_o"},   128'(mem_wdata_o),   128'd0);
        chk({p, ".core_start_o"},  128'(core_start_o),  128'd0);
        chk({p, ".core_raddr_o"},  128'(core_raddr_o),  128'd0);
        chk({p, ".core_weight_o"}, 128'(core_weight_o), 128'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready_o) chk({tag, ".ready_timeout"}, 128'(cmd_ready_o), 128'd1);
    endtask

    // Issue one command; record accept-cycle RAM port values and the response with its latency.
    task automatic do_cmd(input logic [2:0] op, input logic [10:0] addr, input logic [127:0] data);
        wait_ready("cmd");
        cmd_valid_i  = 1'b1;
        cmd_op_i     = op;
        cmd_addr_i   = addr;
        cmd_data_i   = data;
        core_valid_i = 1'($urandom_range(0, 1));
        #1;
        o_we = mem_we_o; o_sel = mem_sel_o; o_ma = mem_addr_o; o_wd = mem_wdata_o;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cmd_op_i    = 3'($urandom);
        o_lat = 1;
        while (!rsp_valid_o && o_lat < 60) begin
            @(negedge clk);
            o_lat++;
        end
        o_rd = rsp_data_o;
        o_err = rsp_err_o;
        core_valid_i = 1'b0;
    endtask

    // START with a non-zero weight; the core reports completion in cycle dly after accept.
    task automatic start_run(input int dly);
        wait_ready("start");
        core_valid_i = 1'b0;
        cmd_valid_i  = 1'b1;
        cmd_op_i     = 3'd5;
        cmd_addr_i   = 11'($urandom);
        cmd_data_i   = {$urandom, $urandom, $urandom, $urandom};
        o_pulses = 0;
        o_busy_lo = 0;
        #1;
        if (core_start_o) o_pulses++;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        o_lat = 1;
        while (!rsp_valid_o && o_lat < dly + 10) begin
            if (core_start_o) o_pulses++;
            if (!busy_o) o_busy_lo++;
            if (o_lat == dly) core_valid_i = 1'b1;
            @(negedge clk);
            core_valid_i = 1'b0;
            o_lat++;
        end
        if (core_start_o) o_pulses++;
        o_rd = rsp_data_o;
        o_err = rsp_err_o;
    endtask

    // Run one command and compare against the model's expected response and RAM port activity.
    task automatic run_op(input logic [2:0] op, input logic [10:0] addr, input logic [127:0] data);
        int e_lat;
        int dly;
        logic [127:0] e_rd;
        logic e_err, e_we, e_sel;
        logic [10:0] e_ma;
        logic [31:0] e_wd;
        e_lat = 1; e_rd = '0; e_err = 1'b0; e_we = 1'b0; e_wd = '0; e_sel = m_sel; e_ma = m_addr;
        if (op == 3'd5 && m_w != 11'd0) begin
            dly = $urandom_range(1, 12);
            start_run(dly);
            chk("start.lat", 128'(o_lat), 128'(dly + 1));
            chk("start.err", 128'(o_err), 128'd0);
            chk("start.data", o_rd, 128'd0);
            chk("start.pulses", 128'(o_pulses), 128'd1);
            chk("start.busy_low", 128'(o_busy_lo), 128'd0);
            m_done = 1'b1;
        end else begin
            case (op)
                3'd0: begin
                    m_done = 1'b0;
                    if (addr < MAXW) begin
                        e_we = 1'b1; e_sel = 1'b0; e_ma = addr; e_wd = 32'(data[15:0]); pos_m[addr] = data[15:0];
                    end else e_err = 1'b1;
                end
                3'd1: begin
                    m_done = 1'b0;
                    if (addr < VECD) begin
                        e_we = 1'b1; e_sel = 1'b1; e_ma = addr; e_wd = data[31:0]; vec_m[addr] = data[31:0];
                    end else e_err = 1'b1;
                end
                3'd2: begin
                    if (RB && addr < MAXW) begin
                        e_lat = 2; e_rd = 128'(pos_m[addr]); e_sel = 1'b0; e_ma = addr;
                    end else e_err = 1'b1;
                end
                3'd3: begin
                    if (RB && addr < VECD) begin
                        e_lat = 2; e_rd = 128'(vec_m[addr]); e_sel = 1'b1; e_ma = addr;
                    end else e_err = 1'b1;
                end
                3'd4: begin
                    if (data[10:0] >= 11'd1 && data[10:0] <= 11'(MAXW)) m_w = data[10:0];
                    else e_err = 1'b1;
                end
                3'd6: begin
                    if (addr < RESD && m_done) begin
                        e_lat = 2; e_rd = 128'(res_ram[addr]);
                    end else e_err = 1'b1;
                end
                default: e_err = 1'b1;
            endcase
            do_cmd(op, addr, data);
            chk("rsp.lat", 128'(o_lat), 128'(e_lat));
            chk("rsp.err", 128'(o_err), 128'(e_err));
            chk("rsp.data", o_rd, e_rd);
            chk("mem.we", 128'(o_we), 128'(e_we));
            chk("mem.addr", 128'(o_ma), 128'(e_ma));
            chk("mem.sel", 128'(o_sel), 128'(e_sel));
            if (e_we) chk("mem.wdata", 128'(o_wd), 128'(e_wd));
            m_addr = e_ma;
            m_sel = e_sel;
        end
        chk("core_weight", 128'(core_weight_o), 128'(m_w));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] op;
        logic [10:0] addr;
        logic [127:0] data;
        int rsp_seen;

        for (int i = 0; i < MAXW; i++) begin pos_ram[i] = '0; pos_m[i] = '0; end
        for (int i = 0; i < VECD; i++) begin vec_ram[i] = '0; vec_m[i] = '0; end
        for (int i = 0; i < RESD; i++) res_ram[i] = $urandom;
        res_ram[0] = 32'h12345678;
        m_w = '0; m_done = 1'b0; m_addr = '0; m_sel = 1'b0;

        rst = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0; cmd_data_i = '0; core_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b1;

        // Position write then readback.
        run_op(3'd0, 11'd3, 128'h1A2B);
        chk("wr_pos.we", 128'(o_we), 128'd1);
        chk("wr_pos.wdata", 128'(o_wd), 128'h1A2B);
        run_op(3'd2, 11'd3, 128'd0);
`ifdef POLY_HOST_READBACK_EN
        chk("rd_pos.data", o_rd, 128'h1A2B);
        chk("rd_pos.lat", 128'(o_lat), 128'd2);
`else
        chk("rd_pos.err", 128'(o_err), 128'd1);
        chk("rd_pos.lat", 128'(o_lat), 128'd1);
`endif

        // Vector RAM boundary.
        run_op(3'd1, 11'd553, 128'h55);
        chk("wr_vec553.we", 128'(o_we), 128'd0);
        chk("wr_vec553.err", 128'(o_err), 128'd1);
        run_op(3'd1, 11'd552, 128'hDEADBEEF);
        chk("wr_vec552.we", 128'(o_we), 128'd1);
        chk("wr_vec552.sel", 128'(o_sel), 128'd1);
        chk("wr_vec552.addr", 128'(o_ma), 128'd552);
        chk("wr_vec552.wdata", 128'(o_wd), 128'hDEADBEEF);

        // Result read before any run completes.
        run_op(3'd6, 11'd0, 128'd0);
        chk("rd_res_early.err", 128'(o_err), 128'd1);

        // Weight 66, start, core done in cycle 40.
        run_op(3'd4, 11'd0, 128'd66);
        chk("set_w66", 128'(core_weight_o), 128'd66);
        start_run(40);
        chk("run40.pulses", 128'(o_pulses), 128'd1);
        chk("run40.busy_low", 128'(o_busy_lo), 128'd0);
        chk("run40.lat", 128'(o_lat), 128'd41);
        chk("run40.err", 128'(o_err), 128'd0);
        m_done = 1'b1;
        run_op(3'd6, 11'd0, 128'd0);
        chk("rd_res0.data", o_rd, 128'h12345678);
        chk("rd_res0.err", 128'(o_err), 128'd0);

`ifndef POLY_HOST_READBACK_EN
        run_op(3'd2, 11'd0, 128'd0);
        chk("rd_pos_off.err", 128'(o_err), 128'd1);
        chk("rd_pos_off.lat", 128'(o_lat), 128'd1);
        chk("rd_pos_off.addr", 128'(o_ma), 128'd552);
        chk("rd_pos_off.we", 128'(o_we), 128'd0);
`endif

        // Randomized command mix.
        for (int k = 0; k < 400; k++) begin
            op = 3'($urandom_range(0, 7));
            data = {$urandom, $urandom, $urandom, $urandom};
            case (op)
                3'd0, 3'd2: addr = 11'($urandom_range(0, MAXW + 3));
                3'd1, 3'd3: addr = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(VECD - 4, VECD + 2))
                                                               : 11'($urandom_range(0, VECD - 1));
                3'd6: addr = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(RESD - 3, RESD + 2))
                                                         : 11'($urandom_range(0, 15));
                default: addr = 11'($urandom);
            endcase
            if (op == 3'd4 && $urandom_range(0, 3) != 0) data[10:0] = 11'($urandom_range(0, MAXW + 5));
            run_op(op, addr, data);
        end

        // Reset in the middle of a run.
        run_op(3'd4, 11'd0, 128'd20);
        wait_ready("midrun");
        cmd_valid_i = 1'b1; cmd_op_i = 3'd5; cmd_addr_i = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun.busy", 128'(busy_o), 128'd1);
        rst = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrun_rst");
        @(negedge clk);
        chk("midrun_rst.rsp_valid", 128'(rsp_valid_o), 128'd0);
        rst = 1'b1;
        #1;
        chk("post_rst.ready", 128'(cmd_ready_o), 128'd1);
        m_done = 1'b0; m_w = '0; m_addr = '0; m_sel = 1'b0;
        rsp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid_o) rsp_seen++;
        end
        chk("post_rst.no_rsp", 128'(rsp_seen), 128'd0);
        run_op(3'd6, 11'd0, 128'd0);
        chk("post_rst.rd_res_err", 128'(o_err), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
